// File: rtl/serial_frame_sender.sv
// serial_frame_sender: queues parallel words in a small FIFO and sends each one
// as a serial frame. A frame is a '1' start bit, the data MSB-first, then
// GAP_BITS low bit-times. The bit rate comes from a clock-enable divider
// (CLKS_PER_BIT), so everything runs on clk.
//
// Optional build macro: SERIAL_FRAME_SENDER_PARITY_EN adds one odd-parity bit
// between the data and the gap.
//
// Ports:
//   clk, rst_n   system clock; asynchronous active-low reset
//   in_data      word to send (WIDTH bits)
//   in_valid     in_data valid
//   in_ready     FIFO not full; a word is written when in_valid && in_ready
//   sout         registered serial output, low when idle
//   busy         high whenever the sender is not idle
//   frame_done   one-cycle pulse on the edge that enters the gap
//   fifo_level   number of words waiting in the FIFO
module serial_frame_sender #(
  parameter int unsigned WIDTH        = 40,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned GAP_BITS     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       sout,
  output logic                       busy,
  output logic                       frame_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);
  localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

`ifdef SERIAL_FRAME_SENDER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, GAP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, GAP} state_e;
`endif

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] count_q;
  logic             push_c, pop_c, empty_c;

  // Sender state
  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end_c;
`ifdef SERIAL_FRAME_SENDER_PARITY_EN
  logic             par_q, par_d;
`endif

  assign empty_c    = (count_q == '0);
  assign in_ready   = (count_q != LVL_W'(DEPTH));
  assign push_c     = in_valid && in_ready;
  assign fifo_level = count_q;
  assign sout       = sout_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign bit_end_c  = (cyc_q == CYC_W'(CLKS_PER_BIT - 1));

  // FIFO data array; no reset needed, validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and level; DEPTH is a power of two so pointers wrap freely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      count_q <= count_q + LVL_W'(1);
      else if (pop_c && !push_c) count_q <= count_q - LVL_W'(1);
    end
  end

  // Sender state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_FRAME_SENDER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_FRAME_SENDER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic; outputs are derived from the next state so they register
  // in step with the state change
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    pop_c   = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_FRAME_SENDER_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != IDLE) cyc_d = bit_end_c ? '0 : cyc_q + CYC_W'(1);

    case (state_q)
      IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          cyc_d   = '0;
          state_d = START;
`ifdef SERIAL_FRAME_SENDER_PARITY_EN
          par_d   = ~^mem_q[rd_ptr_q];
`endif
        end
      end
      START: begin
        if (bit_end_c) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          shreg_d = shreg_q << 1;
          if (bit_q == BIT_W'(WIDTH - 1)) begin
`ifdef SERIAL_FRAME_SENDER_PARITY_EN
            state_d = PARITY;
`else
            gap_d   = '0;
            done_d  = 1'b1;
            state_d = GAP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef SERIAL_FRAME_SENDER_PARITY_EN
      PARITY: begin
        if (bit_end_c) begin
          gap_d   = '0;
          done_d  = 1'b1;
          state_d = GAP;
        end
      end
`endif
      GAP: begin
        if (bit_end_c) begin
          if (gap_q == GAP_W'(GAP_BITS - 1)) begin
            // Chain straight into the next frame when a word is waiting
            if (!empty_c) begin
              pop_c   = 1'b1;
              shreg_d = mem_q[rd_ptr_q];
              state_d = START;
`ifdef SERIAL_FRAME_SENDER_PARITY_EN
              par_d   = ~^mem_q[rd_ptr_q];
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   sout_d = 1'b1;
      DATA:    sout_d = shreg_d[WIDTH-1];
`ifdef SERIAL_FRAME_SENDER_PARITY_EN
      PARITY:  sout_d = par_d;
`endif
      default: sout_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_serial_frame_sender.sv
// Bench for serial_frame_sender: two instances (40-bit/4 clk per bit/2 gap
// bits and 8-bit/1 clk per bit/1 gap bit). Pushed words go to a scoreboard
// queue with their write edge; a per-instance monitor pops a word at each
// frame start and compares the whole frame cycle by cycle.
module tb_serial_frame_sender;

`ifdef SERIAL_FRAME_SENDER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct packed {
    logic [39:0] data;
    int          push_e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] in_data0 = '0;
  logic [7:0]  in_data1 = '0;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic        in_ready0, in_ready1, sout0, sout1, busy0, busy1, fd0, fd1;
  logic [2:0]  lvl0, lvl1;
  logic [1:0]  rdy_a, sout_a, busy_a, fd_a;
  int          ecount = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];

  assign rdy_a  = {in_ready1, in_ready0};
  assign sout_a = {sout1, sout0};
  assign busy_a = {busy1, busy0};
  assign fd_a   = {fd1, fd0};

  serial_frame_sender #(.WIDTH(40), .DEPTH(4), .CLKS_PER_BIT(4), .GAP_BITS(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .sout(sout0), .busy(busy0), .frame_done(fd0),
    .fifo_level(lvl0));

  serial_frame_sender #(.WIDTH(8), .DEPTH(4), .CLKS_PER_BIT(1), .GAP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .sout(sout1), .busy(busy1), .frame_done(fd1),
    .fifo_level(lvl1));

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one cycle of in_valid, returns the write edge
  task automatic push(input int id, input logic [39:0] d, input bit exp_acc, output int p);
    if (id == 0) begin in_valid0 = 1'b1; in_data0 = d; end
    else begin in_valid1 = 1'b1; in_data1 = d[7:0]; end
    check_eq("in_ready", 256'(rdy_a[id]), 256'(exp_acc));
    p = ecount + 1;
    if (exp_acc) exp_q.push_back('{data: d, push_e: p});
    @(negedge clk);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_data0  = 40'({$urandom(), $urandom()});
    in_data1  = 8'($urandom());
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor(input int id, input int w, input int cpb, input int gap);
    int fc, fd_at, prev, want, b, ones;
    bit have_prev, just_done, aborted, par;
    logic [255:0] os, of, ob, es, ef, eb;
    exp_t e;
    fc = (1 + w + PB + gap) * cpb;
    fd_at = (1 + w + PB) * cpb;
    have_prev = 1'b0;
    just_done = 1'b0;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin have_prev = 1'b0; just_done = 1'b0; continue; end
      if (just_done && exp_q.size() == 0 && !sout_a[id])
        check_eq($sformatf("idle_busy%0d", id), 256'(busy_a[id]), 256'(0));
      just_done = 1'b0;
      if (!sout_a[id]) continue;
      if (exp_q.size() == 0) begin
        check_eq($sformatf("spurious_start%0d", id), 256'(sout_a[id]), 256'(0));
        idle_wait(fc);
        continue;
      end
      e = exp_q.pop_front();
      want = e.push_e + 1;
      if (have_prev && prev + fc > want) want = prev + fc;
      check_eq($sformatf("start_edge%0d", id), 256'(ecount), 256'(want));
      prev = ecount;
      have_prev = 1'b1;
      ones = 0;
      for (int k = 0; k < w; k++) ones += int'(e.data[k]);
      par = (ones % 2 == 0);
      es = '0; ef = '0; eb = '0;
      for (int i = 0; i < fc; i++) begin
        b = i / cpb;
        if (b == 0) es[i] = 1'b1;
        else if (b <= w) es[i] = e.data[w - b];
        else if (PB == 1 && b == w + 1) es[i] = par;
        ef[i] = (i == fd_at);
        eb[i] = 1'b1;
      end
      os = '0; of = '0; ob = '0;
      aborted = 1'b0;
      for (int i = 0; i < fc; i++) begin
        if (i > 0) @(negedge clk);
        if (!rst_n) aborted = 1'b1;
        os[i] = sout_a[id];
        of[i] = fd_a[id];
        ob[i] = busy_a[id];
      end
      if (aborted) begin have_prev = 1'b0; continue; end
      check_eq($sformatf("frame_sout%0d", id), os, es);
      check_eq($sformatf("frame_done%0d", id), of, ef);
      check_eq($sformatf("frame_busy%0d", id), ob, eb);
      just_done = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, s, tgt;
    fork
      monitor(0, 40, 4, 2);
      monitor(1, 8, 1, 1);
    join_none

    // Reset values
    idle_wait(3);
    check_eq("rst_sout", 256'(sout0), 256'(0));
    check_eq("rst_busy", 256'(busy0), 256'(0));
    check_eq("rst_done", 256'(fd0), 256'(0));
    check_eq("rst_level", 256'(lvl0), 256'(0));
    check_eq("rst_ready", 256'({in_ready1, in_ready0}), 256'(3));
    rst_n = 1'b1;
    idle_wait(2);

    // Single 40-bit frame
    push(0, 40'hD999999991, 1'b1, p);
    idle_wait(200);
    check_eq("drain_t1", 256'(exp_q.size()), 256'(0));

    // Five consecutive pushes fill the FIFO; a sixth is refused
    push(0, 40'h123456789A, 1'b1, p);
    push(0, 40'hFEDCBA9876, 1'b1, p);
    push(0, 40'h00000000FF, 1'b1, p);
    push(0, 40'h8000000001, 1'b1, p);
    push(0, 40'h5A5A5A5A5A, 1'b1, p);
    check_eq("full_level", 256'(lvl0), 256'(4));
    push(0, 40'hAAAAAAAAAA, 1'b0, p);
    idle_wait(1000);
    check_eq("drain_t2", 256'(exp_q.size()), 256'(0));

    // Push on the gap-end edge while one word waits
    push(0, 40'h0F0F0F0F0F, 1'b1, p);
    s = p + 1;
    push(0, 40'hC3C3C3C3C3, 1'b1, p);
    while (ecount < s + 171) @(negedge clk);
    push(0, 40'h1122334455, 1'b1, p);
    check_eq("pp_level", 256'(lvl0), 256'(1));
    check_eq("pp_ready", 256'(in_ready0), 256'(1));
    idle_wait(400);
    check_eq("drain_t3", 256'(exp_q.size()), 256'(0));

    // Asynchronous reset in the middle of data bit 20 with two words queued
    push(0, 40'h9876543210, 1'b1, p);
    s = p + 1;
    push(0, 40'h1111111111, 1'b1, p);
    push(0, 40'h2222222222, 1'b1, p);
    tgt = s + 21 * 4 + 1;
    while (ecount < tgt) @(negedge clk);
    check_eq("pre_rst_level", 256'(lvl0), 256'(2));
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("async_sout", 256'(sout0), 256'(0));
    check_eq("async_busy", 256'(busy0), 256'(0));
    check_eq("async_level", 256'(lvl0), 256'(0));
    check_eq("async_ready", 256'(in_ready0), 256'(1));
    idle_wait(3);
    rst_n = 1'b1;
    idle_wait(400);
    check_eq("post_rst_level", 256'(lvl0), 256'(0));
    push(0, 40'h0000000001, 1'b1, p);
    idle_wait(200);
    check_eq("drain_t4", 256'(exp_q.size()), 256'(0));

    // 8-bit instance, one clock per bit
    push(1, 40'hA5, 1'b1, p);
    idle_wait(20);
    push(1, 40'h01, 1'b1, p);
    idle_wait(20);
    push(1, 40'h03, 1'b1, p);
    idle_wait(20);
    push(1, 40'h3C, 1'b1, p);
    push(1, 40'hC3, 1'b1, p);
    idle_wait(40);
    check_eq("drain_t5", 256'(exp_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
